// File: rtl/mario_sprite_fetch.sv
// Small-Mario sprite fetch: hit-tests the scan position against the sprite box, addresses the
// sprite ROM, sequences the walk-animation bank and pipelines the palette index to the colour mapper.
module mario_sprite_fetch #(
    parameter int           SPR_W       = 24,
    parameter int           SPR_H       = 32,
    parameter int           N_FRAMES    = 3,
    parameter int           ANIM_DIV    = 6,
    parameter logic [3:0]   TRANSPARENT = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MarioX,
    input  logic [9:0]  MarioY,
    input  logic        facing_left,
    input  logic        moving,
    output logic [9:0]  read_address,
    input  logic [3:0]  rom_data,
    output logic [1:0]  frame_sel,
    output logic        pixel_on,
    output logic [3:0]  palette_idx
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } anim_state_t;

    logic [9:0]         mario_x_r;
    logic [9:0]         mario_y_r;
    logic               facing_r;
    logic               hit_d1_r;
    logic               hit_d2_r;

    logic [10:0]        dx_s;
    logic [10:0]        dy_s;
    logic               hit_s;
    logic [9:0]         col_s;
    logic [9:0]         row_base_s;
    logic [9:0]         addr_s;
    logic               opaque_s;

    anim_state_t        state_r;
    anim_state_t        state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [1:0]         frame_sel_next_s;

    // Shadow position/facing so a whole video frame is drawn from one consistent snapshot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mario_x_r <= 10'd0;
            mario_y_r <= 10'd0;
            facing_r  <= 1'b0;
        end else if (frame_start) begin
            mario_x_r <= MarioX;
            mario_y_r <= MarioY;
            facing_r  <= facing_left;
        end
    end

    // Stage-1 hit test and ROM address; the 11-bit difference exposes negative offsets as misses.
    always_comb begin
        dx_s       = {1'b0, DrawX} - {1'b0, mario_x_r};
        dy_s       = {1'b0, DrawY} - {1'b0, mario_y_r};
        hit_s      = ~dx_s[10] & ~dy_s[10] & (dx_s < 11'(SPR_W)) & (dy_s < 11'(SPR_H));
        row_base_s = dy_s[9:0] * 10'(SPR_W);
        if (facing_r) begin
            col_s = 10'(SPR_W - 1) - dx_s[9:0];
        end else begin
            col_s = dx_s[9:0];
        end
        if (hit_s) begin
            addr_s = row_base_s + col_s;
        end else begin
            addr_s = 10'd0;
        end
        opaque_s = hit_d2_r & (rom_data != TRANSPARENT);
    end

    // Three-stage pixel pipeline: address, ROM access, palette/opacity output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= 10'd0;
            hit_d1_r     <= 1'b0;
            hit_d2_r     <= 1'b0;
            pixel_on     <= 1'b0;
            palette_idx  <= 4'h0;
        end else begin
            read_address <= addr_s;
            hit_d1_r     <= hit_s;
            hit_d2_r     <= hit_d1_r;
            pixel_on     <= opaque_s;
            palette_idx  <= opaque_s ? rom_data : 4'h0;
        end
    end

    // Animation state, divider and bank select registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            frame_sel <= 2'd0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            frame_sel <= frame_sel_next_s;
        end
    end

    // Animation next-state; only frame_start moves it, keeping the bank stable within a frame.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        frame_sel_next_s = frame_sel;
        if (frame_start) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_next_s = '0;
                    if (moving) begin
                        state_next_s     = ST_WALK;
                        frame_sel_next_s = 2'd1;
                    end else begin
                        frame_sel_next_s = 2'd0;
                    end
                end
                ST_WALK: begin
                    if (!moving) begin
                        state_next_s     = ST_IDLE;
                        frame_sel_next_s = 2'd0;
                        cnt_next_s       = '0;
                    end else if (cnt_r == CNT_W'(ANIM_DIV - 1)) begin
                        cnt_next_s = '0;
                        if (frame_sel == 2'(N_FRAMES - 1)) begin
                            frame_sel_next_s = 2'd1;
                        end else begin
                            frame_sel_next_s = frame_sel + 2'd1;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_next_s     = ST_IDLE;
                    frame_sel_next_s = 2'd0;
                    cnt_next_s       = '0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Self-checking bench for mario_sprite_fetch: bench-side ROM, address/pixel scoreboard
// and an independent animation-bank model.
module tb_mario_sprite_fetch;

    localparam int SPR_W    = 24;
    localparam int SPR_H    = 32;
    localparam int N_FRAMES = 3;
    localparam int ANIM_DIV = 6;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] DrawX, DrawY, MarioX, MarioY;
    logic       facing_left, moving;
    logic [9:0] read_address;
    logic [3:0] rom_data;
    logic [1:0] frame_sel;
    logic       pixel_on;
    logic [3:0] palette_idx;

    typedef struct { int due; logic [9:0] addr; } addr_exp_t;
    typedef struct { int due; logic on; logic [3:0] idx; } pix_exp_t;

    addr_exp_t  addr_q[$];
    pix_exp_t   pix_q[$];
    logic [3:0] rom_mem [0:1023];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   sx = 0, sy = 0, walk_n = 0;
    logic sf = 1'b0;
    int   px [8] = '{105, 100, 123, 124,  99, 100, 110, 300};
    int   py [8] = '{210, 200, 231, 210, 210, 202, 199, 100};

    mario_sprite_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .ANIM_DIV(ANIM_DIV), .TRANSPARENT(4'h0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .facing_left(facing_left), .moving(moving), .read_address(read_address),
        .rom_data(rom_data), .frame_sel(frame_sel), .pixel_on(pixel_on), .palette_idx(palette_idx)
    );

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: data valid one cycle after the address.
    always @(posedge Clk) rom_data <= rom_mem[read_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        addr_exp_t ea;
        pix_exp_t  ep;
        @(posedge Clk);
        #1;
        cyc++;
        while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
            ea = addr_q.pop_front();
            check("read_address", 32'(read_address), 32'(ea.addr));
        end
        while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            ep = pix_q.pop_front();
            check("pixel_on", 32'(pixel_on), 32'(ep.on));
            check("palette_idx", 32'(palette_idx), 32'(ep.idx));
        end
    endtask

    task automatic drive_pixel(input int x, input int y);
        int        dx, dy, col, a;
        bit        hit;
        logic [3:0] d;
        addr_exp_t ea;
        pix_exp_t  ep;
        DrawX = 10'(x);
        DrawY = 10'(y);
        dx  = x - sx;
        dy  = y - sy;
        hit = (dx >= 0) && (dx < SPR_W) && (dy >= 0) && (dy < SPR_H);
        col = sf ? (SPR_W - 1 - dx) : dx;
        a   = hit ? (dy * SPR_W + col) : 0;
        d   = rom_mem[a];
        ea.due = cyc + 1; ea.addr = 10'(a);
        ep.due = cyc + 3; ep.on = hit && (d != 4'h0); ep.idx = ep.on ? d : 4'h0;
        addr_q.push_back(ea);
        pix_q.push_back(ep);
        step();
    endtask

    task automatic pulse_frame();
        int exp_fs;
        frame_start = 1'b1;
        sx = int'(MarioX); sy = int'(MarioY); sf = facing_left;
        walk_n = moving ? walk_n + 1 : 0;
        exp_fs = (walk_n == 0) ? 0 : 1 + ((walk_n - 1) / ANIM_DIV) % (N_FRAMES - 1);
        step();
        frame_start = 1'b0;
        check("frame_sel", 32'(frame_sel), 32'(exp_fs));
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic pixel_sweep();
        for (int i = 0; i < 8; i++) drive_pixel(px[i], py[i]);
        flush();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 4'((i * 7) % 16);
        rom_mem[245] = 4'h3;
        rom_mem[258] = 4'h3;
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        MarioX = 10'd0; MarioY = 10'd0; facing_left = 1'b0; moving = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            frame_start = 1'($urandom); DrawX = 10'($urandom); DrawY = 10'($urandom);
            MarioX = 10'($urandom); MarioY = 10'($urandom);
            facing_left = 1'($urandom); moving = 1'($urandom);
            step();
            check("rst_read_address", 32'(read_address), 32'd0);
            check("rst_frame_sel", 32'(frame_sel), 32'd0);
            check("rst_pixel_on", 32'(pixel_on), 32'd0);
            check("rst_palette_idx", 32'(palette_idx), 32'd0);
        end
        frame_start = 1'b0; moving = 1'b0; facing_left = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; MarioX = 10'd0; MarioY = 10'd0;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_x_after_release",
                  32'($isunknown({read_address, frame_sel, pixel_on, palette_idx})), 32'd0);
        end

        // Right-facing hits, misses, transparency, max address
        MarioX = 10'd100; MarioY = 10'd200; facing_left = 1'b0;
        pulse_frame();
        pixel_sweep();

        // Mirrored sprite
        facing_left = 1'b1;
        pulse_frame();
        pixel_sweep();

        // Walk animation sequencing
        moving = 1'b1;
        for (int i = 0; i < 14; i++) begin
            pulse_frame();
            step();
            step();
            check("frame_sel_hold", 32'(frame_sel), 32'(walk_n == 0 ? 0 :
                  1 + ((walk_n - 1) / ANIM_DIV) % (N_FRAMES - 1)));
        end
        moving = 1'b0;
        pulse_frame();
        moving = 1'b1;
        pulse_frame();
        pulse_frame();

        // Mid-frame position change is ignored until the next frame_start
        MarioX = 10'd300;
        drive_pixel(105, 210);
        flush();

        // Asynchronous reset while walking
        check("walk_before_reset", 32'(frame_sel), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("async_frame_sel", 32'(frame_sel), 32'd0);
        check("async_read_address", 32'(read_address), 32'd0);
        check("async_pixel_on", 32'(pixel_on), 32'd0);
        step();
        Reset_n = 1'b1;
        sx = 0; sy = 0; sf = 1'b0; walk_n = 0;
        moving = 1'b0; facing_left = 1'b0; MarioY = 10'd100;
        pulse_frame();
        drive_pixel(305, 105);
        drive_pixel(299, 105);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
